multi_channel_debouncer: RTL and testbench
==========================================

// Module: multi_channel_debouncer
// PURPOSE
// - N_CH-channel debouncer; successor to the single-counter debouncer, generalised in channel count and window.
// - Each channel: 2-FF synchroniser, private stability counter, registered clean level.
// - Sits between raw pad inputs (buttons, switches) and the control logic.
// - Shared tick input stretches the debounce window without widening the counters.
// PARAMETERS
// - N_CH       default 4     number of independent channels (>=1)
// - N_MAX      default 5000  consecutive stable ticks required to accept a new level (>=2)
// - INIT_LVL   default 0     reset value of synchroniser stages and dout (1 bit, same for all channels)
// - CW         derived       counter width = ceillog2(N_MAX), minimum 1; not overridable
// PORTS
// - clk          in   1      system clock, all state on rising edge
// - rst_a_n      in   1      asynchronous reset, active-low
// - tick         in   1      count enable; tie 1 for per-cycle counting
// - din          in   N_CH   raw asynchronous inputs
// - dout         out  N_CH   debounced levels
// - rise         out  N_CH   1-cycle pulse when dout goes 0->1 (macro-gated)
// - fall         out  N_CH   1-cycle pulse when dout goes 1->0 (macro-gated)
// - counter_match out  1     1-cycle pulse when any channel accepts a new level this cycle
// BEHAVIOUR
// - Reset (rst_a_n=0, any time, async): sync stages and dout = {N_CH{INIT_LVL}}; counters = 0; rise/fall/counter_match = 0.
// - Reset mid-count discards partial counts; no pulse is emitted on reset release.
// - Synchroniser: s1 <= din; s2 <= s1. Only s2 feeds the counters.
// - Per channel i, every clk edge:
//   - s2[i]==dout[i]            -> cnt[i] <= 0 (any glitch restarts the window).
//   - s2[i]!=dout[i], tick=0    -> cnt[i] holds.
//   - s2[i]!=dout[i], tick=1, cnt[i]<N_MAX-1 -> cnt[i] <= cnt[i]+1.
//   - s2[i]!=dout[i], tick=1, cnt[i]==N_MAX-1 -> dout[i] <= s2[i]; cnt[i] <= 0; accept event.
// - Mismatch check has priority over tick: equality clears cnt even when tick=0.
// - Latency with tick=1: a clean din edge makes dout change 2+N_MAX clk edges later.
// - Counter never exceeds N_MAX-1; no wrap-around; the comparison is done at CW bits.
// - rise/fall/counter_match registered, asserted the same cycle dout changes, high exactly 1 cycle.
// - Multiple channels accepting on the same cycle: all update; counter_match pulses once.
// - Channels are fully independent; no cross-channel state beyond counter_match OR.
// CONFIGURATION
// - Macro DEBOUNCE_EDGE_PULSE_EN:
//   - defined: rise[i] = accept & s2[i]; fall[i] = accept & ~s2[i] (registered).
//   - undefined: rise and fall driven constant 0, no edge flops synthesised; dout/counter_match unchanged.
// TESTING (bench: N_CH=4, N_MAX=4, INIT_LVL=0, clk 10 ns, macro defined unless stated)
// - Reset: rst_a_n low with din=4'hF -> dout=0, rise=fall=0, counter_match=0 throughout; release -> dout[3:0]=F exactly 6 edges later.
// - Clean edge ch0: din[0] 0->1, tick=1 -> dout[0]=1 on edge 6, rise[0]=1 for that single cycle, counter_match=1 once.
// - Glitch: din[1] high 3 cycles then low -> dout[1] stays 0, no rise, counter_match stays 0.
// - Tick gating: tick=1 every 4th cycle, din[2] 0->1 -> dout[2] changes after 4 ticks (~16 cycles), not after 4 clk.
// - Simultaneous: din 4'b0000->4'b1010 same cycle -> dout=1010 same edge, rise=1010, counter_match single pulse; then 1010->0000 -> fall=1010.
// - Reset mid-count: assert rst_a_n after 2 stable ticks -> no dout change; macro undefined build -> rise=fall=0 in all scenarios.

Source files
------------

// File: rtl/multi_channel_debouncer.sv
// ---------------------------------------------------------------------------
// multi_channel_debouncer
//
// Purpose:
//   Debounces N_CH independent raw pad inputs such as buttons and switches.
//   Each channel has three parts:
//     - a 2-FF synchroniser,
//     - a private stability counter,
//     - a registered clean level.
//   A shared tick input acts as the count enable. Slowing the tick stretches
//   the debounce window without widening the counters.
//
// Parameters:
//   N_CH      number of independent channels (>= 1)
//   N_MAX     consecutive stable ticks needed to accept a new level (>= 2)
//   INIT_LVL  reset level of the synchroniser stages and dout (all channels)
//
// Ports:
//   clk            in   1     system clock; all state changes on the rising edge
//   rst_a_n        in   1     asynchronous reset, active-low
//   tick           in   1     count enable; tie high to count every cycle
//   din            in   N_CH  raw asynchronous inputs
//   dout           out  N_CH  debounced levels
//   rise           out  N_CH  1-cycle pulse when dout goes 0->1
//   fall           out  N_CH  1-cycle pulse when dout goes 1->0
//   counter_match  out  1     1-cycle pulse when any channel accepts a level
//
// Configuration:
//   DEBOUNCE_EDGE_PULSE_EN
//     - Defined: rise and fall are registered edge pulses.
//     - Undefined: rise and fall are tied to 0 and no edge flops are built.
// ---------------------------------------------------------------------------
module multi_channel_debouncer #(
  parameter int   N_CH     = 4,
  parameter int   N_MAX    = 5000,
  parameter logic INIT_LVL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_a_n,
  input  logic            tick,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            counter_match
);

  // The counter runs 0..N_MAX-1, so ceil(log2(N_MAX)) bits suffice.
  // The width never drops below one bit.
  localparam int            CW       = (N_MAX > 2) ? $clog2(N_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_MAX - 1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] r_dout;
  logic            r_match;
  logic [N_CH-1:0] w_mismatch;
  logic [N_CH-1:0] w_accept;

  // Two-stage synchroniser for the raw pad inputs.
  // Only the second stage is allowed to influence the counters.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_sync1 <= {N_CH{INIT_LVL}};
      r_sync2 <= {N_CH{INIT_LVL}};
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Each channel has its own stability counter.
  //
  // When the synchronised input matches the clean level, the count is
  // cleared, even if tick is low. This means any glitch restarts the window.
  //
  // When the input differs, the counter advances only on ticks.
  // When the count reaches N_MAX-1 on a tick, the channel accepts the new
  // level and the counter returns to zero. It therefore never wraps.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;

    assign w_mismatch[g] = r_sync2[g] ^ r_dout[g];
    assign w_accept[g]   = w_mismatch[g] & tick & (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
        r_cnt <= '0;
      end else if (!w_mismatch[g]) begin
        r_cnt <= '0;
      end else if (tick) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // The clean level takes the synchronised value on channels that accept.
  // The match pulse is the OR over all channels. It is therefore a single
  // pulse even when several channels accept on the same edge.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_dout  <= {N_CH{INIT_LVL}};
      r_match <= 1'b0;
    end else begin
      r_dout  <= (r_dout & ~w_accept) | (r_sync2 & w_accept);
      r_match <= |w_accept;
    end
  end

  assign dout          = r_dout;
  assign counter_match = r_match;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;

  // Edge pulses are registered alongside dout, so they line up with the
  // level change. The direction comes from the value being accepted.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_accept & r_sync2;
      r_fall <= w_accept & ~r_sync2;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_debouncer
//
// Bench configuration: N_CH=4, N_MAX=4, INIT_LVL=0, 10 ns clock.
//
// Each scenario pushes the cycle-by-cycle outputs it expects into a queue.
// It then pops one entry per clock edge and compares it with the sampled DUT
// outputs, 1 ns after the rising edge.
//
// When DEBOUNCE_EDGE_PULSE_EN is undefined, the expected rise/fall are
// masked to zero.
// ---------------------------------------------------------------------------
module tb_multi_channel_debouncer;

  localparam int N_CH  = 4;
  localparam int N_MAX = 4;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam logic [3:0] EDGE_MASK = 4'hF;
`else
  localparam logic [3:0] EDGE_MASK = 4'h0;
`endif

  typedef struct packed {
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       match;
  } expT;

  logic       clk;
  logic       rst_a_n;
  logic       tick;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       counter_match;

  expT expQ[$];
  expT observed;
  expT expected;
  int  testsRun    = 0;
  int  testsFailed = 0;

  multi_channel_debouncer #(
    .N_CH    (N_CH),
    .N_MAX   (N_MAX),
    .INIT_LVL(1'b0)
  ) dut (
    .clk          (clk),
    .rst_a_n      (rst_a_n),
    .tick         (tick),
    .din          (din),
    .dout         (dout),
    .rise         (rise),
    .fall         (fall),
    .counter_match(counter_match)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queues len expected output samples for one phase.
  // The level moves from prevLvl to newLvl on edge changeEdge, counted from 1.
  // That edge also carries the edge pulses and the match pulse.
  // A changeEdge beyond len means the outputs stay quiet for the whole phase.
  function automatic void pushPhase(input logic [3:0] prevLvl,
                                    input logic [3:0] newLvl,
                                    input int changeEdge,
                                    input int len);
    expT e;
    for (int k = 1; k <= len; k++) begin
      e.dout  = (k < changeEdge) ? prevLvl : newLvl;
      e.rise  = (k == changeEdge) ? (newLvl & ~prevLvl & EDGE_MASK) : 4'h0;
      e.fall  = (k == changeEdge) ? (~newLvl & prevLvl & EDGE_MASK) : 4'h0;
      e.match = (k == changeEdge) && (newLvl != prevLvl);
      expQ.push_back(e);
    end
  endfunction

  // Asserting reset with all inputs high must force quiet outputs
  // asynchronously and keep them quiet over several edges. After release,
  // the high inputs appear on dout exactly 6 edges later.
  task automatic test_reset();
    rst_a_n = 1'b1;
    din     = 4'hF;
    tick    = 1'b1;
    #1;
    rst_a_n = 1'b0;
    #2;
    observed = {dout, rise, fall, counter_match};
    testsRun++;
    if (observed !== 13'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: got %b expected %b", observed, 13'h0);
    end
    pushPhase(4'h0, 4'h0, 99, 3);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold edge %0d: got %b expected %b", k, observed, expected);
      end
    end
    rst_a_n = 1'b1;
    pushPhase(4'h0, 4'hF, 6, 7);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL reset_release edge %0d: got %b expected %b", k, observed, expected);
      end
    end
  endtask

  // All channels drop together and should fall on the same edge.
  task automatic test_all_fall();
    din = 4'h0;
    pushPhase(4'hF, 4'h0, 6, 8);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL all_fall edge %0d: got %b expected %b", k, observed, expected);
      end
    end
  endtask

  // A clean 0->1 edge on channel 0 is accepted on edge 2+N_MAX.
  task automatic test_clean_edge();
    din = 4'b0001;
    pushPhase(4'b0000, 4'b0001, 6, 8);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL clean_edge edge %0d: got %b expected %b", k, observed, expected);
      end
    end
  endtask

  // Channel 1 is high for only N_MAX-1 cycles, one short of acceptance.
  // The output must not move.
  task automatic test_glitch();
    pushPhase(4'b0001, 4'b0001, 99, 10);
    for (int k = 1; k <= 10; k++) begin
      din = {2'b00, (k <= 3), 1'b1};
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL glitch edge %0d: got %b expected %b", k, observed, expected);
      end
    end
  endtask

  // Channel 1 is high for exactly N_MAX cycles, the shortest accepted pulse.
  // It must rise on edge 6 and fall again N_MAX edges later.
  task automatic test_min_pulse();
    pushPhase(4'b0001, 4'b0011, 6, 6);
    pushPhase(4'b0011, 4'b0001, 4, 6);
    for (int k = 1; k <= 12; k++) begin
      din = {2'b00, (k <= 4), 1'b1};
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL min_pulse edge %0d: got %b expected %b", k, observed, expected);
      end
    end
  endtask

  // With tick high every 4th cycle, channel 2 needs four ticks, not four
  // clocks. The counted ticks fall on edges 4, 8, 12 and 16, so the change
  // lands on edge 16.
  task automatic test_tick_gating();
    din = 4'b0101;
    pushPhase(4'b0001, 4'b0101, 16, 18);
    for (int k = 1; k <= 18; k++) begin
      tick = ((k % 4) == 0);
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL tick_gating edge %0d: got %b expected %b", k, observed, expected);
      end
    end
    tick = 1'b1;
  endtask

  // Multiple channels change on the same cycle, in both directions, phase
  // after phase. Each phase must produce a single match pulse.
  task automatic test_back_to_back();
    logic [3:0] targets [3];
    logic [3:0] prevLvl;
    targets[0] = 4'b0000;
    targets[1] = 4'b1010;
    targets[2] = 4'b0000;
    prevLvl    = 4'b0101;
    for (int p = 0; p < 3; p++) begin
      din = targets[p];
      pushPhase(prevLvl, targets[p], 6, 8);
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk);
        #1;
        expected = expQ.pop_front();
        observed = {dout, rise, fall, counter_match};
        testsRun++;
        if (observed !== expected) begin
          testsFailed++;
          $display("[TB] FAIL back_to_back phase %0d edge %0d: got %b expected %b",
                   p, k, observed, expected);
        end
      end
      prevLvl = targets[p];
    end
  endtask

  // Reset arrives after two counted ticks. The partial count must be lost.
  // After release, the change must again take the full 2+N_MAX edges, with
  // no pulse on release.
  task automatic test_mid_reset();
    din  = 4'b0001;
    tick = 1'b1;
    pushPhase(4'b0000, 4'b0000, 99, 4);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL mid_reset_pre edge %0d: got %b expected %b", k, observed, expected);
      end
    end
    rst_a_n = 1'b0;
    #2;
    observed = {dout, rise, fall, counter_match};
    testsRun++;
    if (observed !== 13'h0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_async: got %b expected %b", observed, 13'h0);
    end
    pushPhase(4'b0000, 4'b0000, 99, 2);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL mid_reset_hold edge %0d: got %b expected %b", k, observed, expected);
      end
    end
    rst_a_n = 1'b1;
    pushPhase(4'b0000, 4'b0001, 6, 8);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      expected = expQ.pop_front();
      observed = {dout, rise, fall, counter_match};
      testsRun++;
      if (observed !== expected) begin
        testsFailed++;
        $display("[TB] FAIL mid_reset_release edge %0d: got %b expected %b", k, observed, expected);
      end
    end
  endtask

  // Runs the scenarios in sequence. Each one starts from the levels the
  // previous one left behind.
  initial begin
    rst_a_n = 1'b1;
    tick    = 1'b1;
    din     = 4'h0;
    test_reset();
    test_all_fall();
    test_clean_edge();
    test_glitch();
    test_min_pulse();
    test_tick_gating();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
